// File: rtl/ras_predictor.sv
// Return-address stack predictor: classifies RV32 calls/returns, predicts targets, emits TOS/count checkpoints.
// Latency: prediction and checkpoint are combinational in the fetch cycle; stack state updates on the next clk edge.
// Backpressure: fetch_stall freezes state while still presenting the prediction; flush overrides any fetch.
module ras_predictor #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int PTRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    input  logic             fetch_stall,
    input  logic [WIDTH-1:0] fetch_pc,
    input  logic [31:0]      fetch_instr,
    output logic             pred_valid,
    output logic [WIDTH-1:0] pred_target,
    output logic [PTRW-1:0]  ckpt_tos,
    output logic [PTRW:0]    ckpt_cnt,
    input  logic             flush,
    input  logic [PTRW-1:0]  flush_tos,
    input  logic [PTRW:0]    flush_cnt
);
    localparam logic [PTRW:0]   CNT_MAX = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0]   CNT_ONE = (PTRW+1)'(1);
    localparam logic [PTRW-1:0] TOS_ONE = PTRW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  tos, tos_nxt, wr_idx;
    logic [PTRW:0]    cnt, cnt_nxt;
    logic             wr_en;

    logic [6:0]       opcode;
    logic [4:0]       rd, rs1;
    logic [2:0]       funct3;
    logic [11:0]      unused_instr;
    logic             is_jal, is_jalr, rdl, rs1l;
    logic             do_push, do_pop, do_poppush;
    logic [WIDTH-1:0] link_addr;

    assign opcode       = fetch_instr[6:0];
    assign rd           = fetch_instr[11:7];
    assign funct3       = fetch_instr[14:12];
    assign rs1          = fetch_instr[19:15];
    assign unused_instr = fetch_instr[31:20];

    assign is_jal  = (opcode == 7'b1101111);
    assign is_jalr = (opcode == 7'b1100111) && (funct3 == 3'b000);
    assign rdl     = (rd == 5'd1) || (rd == 5'd5);
    assign rs1l    = (rs1 == 5'd1) || (rs1 == 5'd5);

    // jalr with both link registers equal is a plain call (RISC-V hint table)
    assign do_push    = fetch_valid & ((is_jal & rdl) |
                                       (is_jalr & rdl & (~rs1l | (rd == rs1))));
    assign do_pop     = fetch_valid & is_jalr & rs1l & ~rdl;
    assign do_poppush = fetch_valid & is_jalr & rdl & rs1l & (rd != rs1);

    assign link_addr = fetch_pc + WIDTH'(4);

    always_comb begin
        tos_nxt = tos;
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_idx  = tos;
        if (!fetch_stall) begin
            if (do_push) begin
                tos_nxt = tos + TOS_ONE;
                wr_idx  = tos + TOS_ONE;
                wr_en   = 1'b1;
                if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_ONE;
            end else if (do_pop) begin
                if (cnt != '0) begin
                    tos_nxt = tos - TOS_ONE;
                    cnt_nxt = cnt - CNT_ONE;
                end
            end else if (do_poppush) begin
                wr_en = 1'b1;
                if (cnt == '0) cnt_nxt = CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos <= '0;
            cnt <= '0;
        end else if (flush) begin
            tos <= flush_tos;
            cnt <= flush_cnt;
        end else if (fetch_valid && !fetch_stall) begin
            tos <= tos_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Storage is never cleared; cnt alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en && !flush) mem[wr_idx] <= link_addr;
    end

    assign pred_valid  = rst_n & (do_pop | do_poppush) & (cnt != '0);
    assign pred_target = pred_valid ? mem[tos] : '0;
    assign ckpt_tos    = rst_n ? tos_nxt : '0;
    assign ckpt_cnt    = rst_n ? cnt_nxt : '0;
endmodule

// File: tb/tb_ras_predictor.sv
// Bench for ras_predictor: directed vector table, hand-written corner sequences, randomized run vs reference model.
module tb_ras_predictor;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int PTRW  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fetch_valid = 1'b0;
    logic             fetch_stall = 1'b0;
    logic [WIDTH-1:0] fetch_pc = '0;
    logic [31:0]      fetch_instr = '0;
    logic             flush = 1'b0;
    logic [PTRW-1:0]  flush_tos = '0;
    logic [PTRW:0]    flush_cnt = '0;
    logic             pred_valid;
    logic [WIDTH-1:0] pred_target;
    logic [PTRW-1:0]  ckpt_tos;
    logic [PTRW:0]    ckpt_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ras_predictor #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(fetch_valid), .fetch_stall(fetch_stall),
        .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .pred_valid(pred_valid), .pred_target(pred_target),
        .ckpt_tos(ckpt_tos), .ckpt_cnt(ckpt_cnt),
        .flush(flush), .flush_tos(flush_tos), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic        v;
        logic        st;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        fl;
        logic [3:0]  ft;
        logic [4:0]  fc;
        logic        e_pv;
        logic [31:0] e_pt;
        logic        ck;
        logic [3:0]  e_tos;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] f_jal(input logic [4:0] rd);
        return {20'h10000, rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] f_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [2:0] f3);
        return {12'h000, rs1, f3, rd, 7'b1100111};
    endfunction

    // 0 none, 1 push, 2 pop, 3 pop-then-push
    function automatic int classify(input logic v, input logic [31:0] ins);
        logic [4:0] rd, rs1;
        bit jal, jalr, rdl, rs1l;
        rd   = ins[11:7];
        rs1  = ins[19:15];
        jal  = (ins[6:0] == 7'h6F);
        jalr = (ins[6:0] == 7'h67) && (ins[14:12] == 3'd0);
        rdl  = (rd == 5'd1) || (rd == 5'd5);
        rs1l = (rs1 == 5'd1) || (rs1 == 5'd5);
        if (!v) return 0;
        if (jal && rdl) return 1;
        if (jalr && rdl && !rs1l) return 1;
        if (jalr && rdl && rs1l) return (rd == rs1) ? 1 : 3;
        if (jalr && rs1l) return 2;
        return 0;
    endfunction

    task automatic add(input logic v, input logic st, input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic [3:0] ft, input logic [4:0] fc,
                       input logic pv, input logic [31:0] pt, input logic ck,
                       input logic [3:0] et, input logic [4:0] ec);
        vec_t r;
        r.v = v; r.st = st; r.pc = pc; r.ins = ins; r.fl = fl; r.ft = ft; r.fc = fc;
        r.e_pv = pv; r.e_pt = pt; r.ck = ck; r.e_tos = et; r.e_cnt = ec;
        vecs.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic st, input logic [31:0] pc, input logic [31:0] ins,
                         input logic fl, input logic [3:0] ft, input logic [4:0] fc);
        fetch_valid = v; fetch_stall = st; fetch_pc = pc; fetch_instr = ins;
        flush = fl; flush_tos = ft; flush_cnt = fc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        drive(1'b1, 1'b0, 32'h1234, f_jal(5'd1), 1'b0, 4'd0, 5'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst pred_valid", pred_valid, 0);
        chk("rst ckpt_cnt", ckpt_cnt, 0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h13, 1'b0, 4'd0, 5'd0);
        rst_n = 1'b1;
        #1;
    endtask

    logic [31:0] RET;
    logic [31:0] m_mem [DEPTH];
    int m_tos, m_cnt;

    initial begin
        RET = f_jalr(5'd0, 5'd1, 3'd0);

        add(1,0,32'h1000,f_jal(1),0,0,0, 0,32'h0,   1,1,1);
        add(1,0,32'h1100,RET,0,0,0,       1,32'h1004,1,0,0);
        add(1,0,32'h1104,RET,0,0,0,       0,32'h0,   1,0,0);
        add(0,0,32'h1108,RET,0,0,0,       0,32'h0,   1,0,0);
        add(1,0,32'h3000,f_jal(1),0,0,0,  0,32'h0,   1,1,1);
        add(1,0,32'h4000,f_jalr(5,1,0),0,0,0, 1,32'h3004,1,1,1);
        add(1,0,32'h4100,f_jalr(0,5,0),0,0,0, 1,32'h4004,1,0,0);
        add(1,0,32'h5000,f_jal(1),0,0,0,  0,32'h0,   1,1,1);
        add(1,0,32'h5100,f_jal(1),0,0,0,  0,32'h0,   1,2,2);
        add(1,0,32'h5200,RET,0,0,0,       1,32'h5104,1,1,1);
        add(1,0,32'h5204,RET,0,0,0,       1,32'h5004,1,0,0);
        add(1,0,32'h5208,RET,0,0,0,       0,32'h0,   1,0,0);
        add(1,0,32'h6000,f_jal(1),1,2,2,  0,32'h0,   0,0,0);
        add(1,0,32'h6100,RET,0,0,0,       1,32'h5104,1,1,1);
        add(1,0,32'h6104,RET,0,0,0,       1,32'h5004,1,0,0);
        add(1,0,32'h7000,f_jalr(1,1,0),0,0,0, 0,32'h0,1,1,1);
        add(1,0,32'h7100,f_jalr(1,5,0),0,0,0, 1,32'h7004,1,1,1);
        add(1,0,32'h7200,f_jalr(0,1,1),0,0,0, 0,32'h0,1,1,1);
        add(1,0,32'h7204,RET,0,0,0,       1,32'h7104,1,0,0);
        add(1,0,32'h8000,f_jal(0),0,0,0,  0,32'h0,   1,0,0);
        add(1,0,32'h8FFC,f_jal(5),0,0,0,  0,32'h0,   1,1,1);
        add(1,0,32'h9100,f_jalr(0,5,0),0,0,0, 1,32'h9000,1,0,0);
        add(1,0,32'hFFFFFFFC,f_jal(1),0,0,0, 0,32'h0,1,1,1);
        add(1,0,32'h9200,RET,0,0,0,       1,32'h0,   1,0,0);

        // Reset state: outputs forced low while rst_n is asserted, even with a call presented
        drive(1'b1, 1'b0, 32'h1000, f_jal(5'd1), 1'b0, 4'd0, 5'd0);
        #3;
        chk("reset pred_valid", pred_valid, 0);
        chk("reset pred_target", pred_target, 0);
        chk("reset ckpt_tos", ckpt_tos, 0);
        chk("reset ckpt_cnt", ckpt_cnt, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h13, 1'b0, 4'd0, 5'd0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].st, vecs[i].pc, vecs[i].ins, vecs[i].fl, vecs[i].ft, vecs[i].fc);
            #3;
            chk($sformatf("vec%0d pred_valid", i), pred_valid, vecs[i].e_pv);
            chk($sformatf("vec%0d pred_target", i), pred_target, vecs[i].e_pt);
            if (vecs[i].ck) begin
                chk($sformatf("vec%0d ckpt_tos", i), ckpt_tos, vecs[i].e_tos);
                chk($sformatf("vec%0d ckpt_cnt", i), ckpt_cnt, vecs[i].e_cnt);
            end
            tick();
        end

        // Overflow: 18 calls into a 16-entry stack, then 18 returns
        reset_pulse();
        for (int k = 0; k < 18; k++) begin
            drive(1'b1, 1'b0, 32'h2000 + 32'(4 * k), f_jal(5'd1), 1'b0, 4'd0, 5'd0);
            #3;
            chk($sformatf("ovf call%0d ckpt_cnt", k), ckpt_cnt, (k + 1 > 16) ? 16 : k + 1);
            chk($sformatf("ovf call%0d ckpt_tos", k), ckpt_tos, (k + 1) % 16);
            tick();
        end
        for (int j = 1; j <= 18; j++) begin
            int jj;
            jj = (j > 16) ? 16 : j;
            drive(1'b1, 1'b0, 32'h2800, RET, 1'b0, 4'd0, 5'd0);
            #3;
            chk($sformatf("ovf ret%0d pred_valid", j), pred_valid, (j <= 16) ? 1 : 0);
            chk($sformatf("ovf ret%0d pred_target", j), pred_target,
                (j <= 16) ? 32'h2048 - 32'(4 * (j - 1)) : 32'h0);
            chk($sformatf("ovf ret%0d ckpt_cnt", j), ckpt_cnt, 16 - jj);
            chk($sformatf("ovf ret%0d ckpt_tos", j), ckpt_tos, (2 - jj + 32) % 16);
            tick();
        end

        // Stall: a held return keeps predicting but pops once, when the stall drops
        reset_pulse();
        drive(1'b1, 1'b0, 32'hA000, f_jal(5'd1), 1'b0, 4'd0, 5'd0);
        #3;
        chk("stall call ckpt_cnt", ckpt_cnt, 1);
        tick();
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 1'b1, 32'hA100, RET, 1'b0, 4'd0, 5'd0);
            #3;
            chk($sformatf("stall%0d pred_valid", s), pred_valid, 1);
            chk($sformatf("stall%0d pred_target", s), pred_target, 32'hA004);
            chk($sformatf("stall%0d ckpt_cnt", s), ckpt_cnt, 1);
            chk($sformatf("stall%0d ckpt_tos", s), ckpt_tos, 1);
            tick();
        end
        drive(1'b1, 1'b0, 32'hA100, RET, 1'b0, 4'd0, 5'd0);
        #3;
        chk("unstall pred_valid", pred_valid, 1);
        chk("unstall pred_target", pred_target, 32'hA004);
        chk("unstall ckpt_cnt", ckpt_cnt, 0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h13, 1'b0, 4'd0, 5'd0);
        #3;
        chk("after stall ckpt_cnt", ckpt_cnt, 0);
        chk("after stall ckpt_tos", ckpt_tos, 0);
        tick();

        // Randomized run against a behavioural model of the stack
        reset_pulse();
        m_tos = 0;
        m_cnt = 0;
        foreach (m_mem[i]) m_mem[i] = '0;
        begin
            logic [8:0] hist[$];
            for (int c = 0; c < 600; c++) begin
                logic v, st, fl, e_pv;
                logic [31:0] pc, ins, e_pt;
                logic [3:0] ft;
                logic [4:0] fc, rd, rs1;
                logic [2:0] f3;
                int cls, n_tos, n_cnt, sel;

                v  = ($urandom_range(0, 9) != 0);
                st = ($urandom_range(0, 4) == 0);
                fl = (hist.size() > 0) && ($urandom_range(0, 11) == 0);
                ft = '0;
                fc = '0;
                if (fl) {ft, fc} = hist[$urandom_range(0, hist.size() - 1)];
                pc  = $urandom;
                sel = $urandom_range(0, 3);
                rd  = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd1 : (sel == 2) ? 5'd5 : 5'($urandom_range(0, 31));
                sel = $urandom_range(0, 3);
                rs1 = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd1 : (sel == 2) ? 5'd5 : 5'($urandom_range(0, 31));
                f3  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
                case ($urandom_range(0, 5))
                    0:       ins = f_jal(rd);
                    1, 2, 3: ins = f_jalr(rd, rs1, f3);
                    4:       ins = 32'h13;
                    default: ins = $urandom;
                endcase

                cls   = classify(v, ins);
                e_pv  = (cls == 2 || cls == 3) && (m_cnt != 0);
                e_pt  = e_pv ? m_mem[m_tos] : 32'h0;
                n_tos = m_tos;
                n_cnt = m_cnt;
                if (!st) begin
                    if (cls == 1) begin
                        n_tos = (m_tos + 1) % DEPTH;
                        n_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
                    end else if (cls == 2 && m_cnt > 0) begin
                        n_tos = (m_tos + DEPTH - 1) % DEPTH;
                        n_cnt = m_cnt - 1;
                    end else if (cls == 3) begin
                        n_cnt = (m_cnt == 0) ? 1 : m_cnt;
                    end
                end

                drive(v, st, pc, ins, fl, ft, fc);
                #3;
                chk($sformatf("rnd%0d pred_valid", c), pred_valid, e_pv);
                chk($sformatf("rnd%0d pred_target", c), pred_target, e_pt);
                if (!fl) begin
                    chk($sformatf("rnd%0d ckpt_tos", c), ckpt_tos, n_tos);
                    chk($sformatf("rnd%0d ckpt_cnt", c), ckpt_cnt, n_cnt);
                end

                if (fl) begin
                    m_tos = ft;
                    m_cnt = fc;
                end else if (v && !st) begin
                    if (cls == 1) m_mem[n_tos] = pc + 32'd4;
                    if (cls == 3) m_mem[m_tos] = pc + 32'd4;
                    m_tos = n_tos;
                    m_cnt = n_cnt;
                end
                hist.push_back({4'(m_tos), 5'(m_cnt)});
                if (hist.size() > 32) void'(hist.pop_front());
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ras_predictor.md
Name: ras_predictor

Overview:
- Front-end controller and consumer for the return-address stack.
- Decodes each fetched RV32 instruction and classifies it as a call, a return, or both.
- Pushes the link address, pops and predicts return targets, and hands a checkpoint (TOS pointer plus count) down the pipeline.
- Internal storage is a circular stack: the oldest entry is overwritten on overflow. Pointer state is restored from a checkpoint when EX flushes.

Parameters:
- WIDTH, 32: address width.
- DEPTH, 16: stack entries; must be a power of two, at least 2.
- PTRW, $clog2(DEPTH): TOS pointer width (derived; do not override).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- fetch_valid  input  1  fetch_pc/fetch_instr valid this cycle.
- fetch_stall  input  1  fetch held; no state update.
- fetch_pc  input  WIDTH  PC of fetched instruction.
- fetch_instr  input  32  fetched instruction word.
- pred_valid  output  1  return predicted this cycle.
- pred_target  output  WIDTH  predicted return target.
- ckpt_tos  output  PTRW  TOS pointer after this instruction's RAS operation.
- ckpt_cnt  output  PTRW+1  entry count after this instruction's RAS operation.
- flush  input  1  EX redirect; restore state.
- flush_tos  input  PTRW  checkpoint pointer from the flushing instruction.
- flush_cnt  input  PTRW+1  checkpoint count from the flushing instruction.

Behaviour:
- State: mem[DEPTH] (not reset), tos (index of top valid entry), cnt (valid entries, 0..DEPTH).
- Reset, asynchronous on rst_n low: tos=0, cnt=0.
- All outputs are combinational from state and inputs. With reset asserted, pred_valid=0, pred_target=0, ckpt_tos=0, ckpt_cnt=0.
- Decode. Link register means x1 or x5.
  - jal: opcode 1101111.
  - jalr: opcode 1100111 and funct3=000.
  - rdl: rd is link. rs1l: rs1 is link.
- Classification:
  - PUSH: jal with rdl; or jalr with rdl and not rs1l; or jalr with rdl, rs1l and rd==rs1.
  - POP: jalr with rs1l and not rdl.
  - POPPUSH: jalr with rdl, rs1l and rd!=rs1.
  - NONE: everything else, including any instruction when fetch_valid=0.
- Prediction:
  - pred_valid = fetch_valid & (POP|POPPUSH) & (cnt!=0).
  - pred_target = mem[tos] when pred_valid, else 0.
  - Asserted during stall as well; the prediction is zero-latency and the same cycle as fetch.
- Update: one per cycle, on the clk edge, when fetch_valid & ~fetch_stall & ~flush.
  - PUSH: mem[tos+1] <= fetch_pc+4 (mod 2^WIDTH); tos <= tos+1 (wraps mod DEPTH); cnt <= min(cnt+1, DEPTH). At cnt=DEPTH the oldest entry is silently overwritten.
  - POP with cnt>0: tos <= tos-1 (wraps); cnt <= cnt-1.
  - POP with cnt=0: no change, no prediction.
  - POPPUSH: mem[tos] <= fetch_pc+4; tos unchanged; cnt <= max(cnt,1).
  - NONE: no change.
- ckpt_tos/ckpt_cnt carry the next-state values computed as above. Under stall or NONE they equal the current tos/cnt.
- Flush has priority over fetch in the same cycle: tos <= flush_tos, cnt <= flush_cnt, and the fetch operation is discarded. mem is not modified. Entries overwritten on the wrong path are not recovered; this is an accepted accuracy loss.
- flush_cnt > DEPTH is illegal input; the bench must not drive it.
- Reset mid-operation: state clears immediately; the next edge after rst_n deasserts behaves as from empty.

Test Plan:
- Reset, then fetch `jal x1,+0x100` at pc=0x1000. Next cycle, fetch `jalr x0,0(x1)` → pred_valid=1, pred_target=0x1004. After that cycle cnt=0 and ckpt_cnt=0.
- Empty return: after reset, fetch `jalr x0,0(x1)` → pred_valid=0, pred_target=0; tos and cnt unchanged.
- Overflow: DEPTH+2=18 calls at pc=0x2000+4k (k=0..17), then 18 returns.
  - Returns 1-16 predict 0x2048 down to 0x200C.
  - cnt saturates at 16; returns 17 and 18 give pred_valid=0.
- POPPUSH: call at pc=0x3000, then `jalr x5,0(x1)` at pc=0x4000 → pred_target=0x3004. A following return via x5 predicts 0x4004, with cnt=1 throughout.
- Flush priority:
  - Capture ckpt (tos=2, cnt=2) after two calls, then perform 3 wrong-path returns.
  - Assert flush with that ckpt in the same cycle as a call → the call is ignored, tos=2, cnt=2.
  - The next return predicts the second call's pc+4.
- Stall: hold fetch_stall=1 with a return presented for 3 cycles → pred_valid stays 1 each cycle; cnt decrements exactly once, on the cycle stall drops.
